// File: rtl/spk_out_pack.sv
// spk_out_pack: spike output packer.
// Queues the IDs of neurons that fired. For each queued neuron it scans the
// destination table in ascending index order and emits one NoC spike flit per
// valid entry on a valid/ready output port.
//
// Output handshake: flit_out_vld is set only together with a freshly
// registered flit_out. While flit_out_vld=1 and flit_out_rdy=0, both are held
// unchanged. The flit is transferred on the rising edge where
// flit_out_vld=1 and flit_out_rdy=1. flit_out_vld never depends
// combinationally on flit_out_rdy.

module spk_out_pack #(
    parameter int FW                 = 59,
    parameter int FTW                = 3,
    parameter int NNW                = 12,
    parameter int SW                 = 24,
    parameter int DST_WIDTH          = 21,
    parameter int DST_DEPTH          = 4,
    parameter int FIFO_AW            = 4,
    parameter logic [FTW-1:0] SPK_TYPE = 3'b000,
    localparam int DAW               = $clog2(DST_DEPTH)
) (
    input  logic                 clk_spk_out,
    input  logic                 rst_n,
    input  logic                 soma_spk_out_vld,
    input  logic                 soma_spk_out_fire,
    input  logic [NNW-1:0]       soma_spk_out_nid,
    input  logic                 config_spk_enable,
    input  logic                 config_spk_clear,
    input  logic [SW-1:0]        config_spk_base,
    input  logic                 config_dst_we,
    input  logic [DAW-1:0]       config_dst_waddr,
    input  logic [DST_WIDTH-1:0] config_dst_wdata,
    output logic [FW-1:0]        flit_out,
    output logic                 flit_out_vld,
    input  logic                 flit_out_rdy,
    output logic                 spk_out_busy,
    output logic [15:0]          spk_drop_cnt
);

    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam int PADW       = FW - FTW - DST_WIDTH - SW;
    localparam logic [DAW-1:0]     IDX_LAST  = DAW'(DST_DEPTH - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Neuron-ID FIFO
    // ------------------------------------------------------------------
    logic [NNW-1:0]     fifo_mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q,  count_d;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic               drop;

    // ------------------------------------------------------------------
    // Destination table and FSM registers
    // ------------------------------------------------------------------
    logic [DST_WIDTH-1:0] dst_tbl_q [DST_DEPTH];
    state_t               state_q,   state_d;
    logic [DAW-1:0]       idx_q,     idx_d;
    logic [NNW-1:0]       cur_nid_q, cur_nid_d;
    logic [FW-1:0]        flit_q,    flit_d;
    logic                 vld_q,     vld_d;
    logic [15:0]          drop_q,    drop_d;
    logic [DST_WIDTH-1:0] cur_entry;
    logic [SW-1:0]        payload;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);

    // A clear cycle discards any incoming spike and blocks the pop, so the
    // FIFO really is empty on the following edge.
    assign push_req = soma_spk_out_vld & soma_spk_out_fire & config_spk_enable
                      & ~config_spk_clear;
    assign pop      = (state_q == ST_IDLE) & ~fifo_empty & ~config_spk_clear;
    assign push_ok  = push_req & (~fifo_full | pop);
    assign drop     = push_req & fifo_full & ~pop;

    // FIFO pointer and occupancy next-state; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer/occupancy registers; clear empties the queue.
    always_ff @(posedge clk_spk_out) begin
        if (!rst_n || config_spk_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage: data only, validity is tracked by the pointers.
    always_ff @(posedge clk_spk_out) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= soma_spk_out_nid;
        end
    end

    // Saturating drop counter next-state; survives clear.
    always_comb begin
        drop_d = drop_q;
        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk_spk_out) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    // Destination table: writable at any time, cleared only by reset.
    always_ff @(posedge clk_spk_out) begin
        if (!rst_n) begin
            for (int i = 0; i < DST_DEPTH; i++) begin
                dst_tbl_q[i] <= '0;
            end
        end else if (config_dst_we && (int'(config_dst_waddr) < DST_DEPTH)) begin
            dst_tbl_q[config_dst_waddr] <= config_dst_wdata;
        end
    end

    // SCAN looks at the table contents as they stand in the current cycle.
    assign cur_entry = dst_tbl_q[idx_q];
    assign payload   = config_spk_base + SW'(cur_nid_q);

    // Fan-out FSM next-state: pop a neuron, walk the table, send one flit per
    // valid entry.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cur_nid_d = cur_nid_q;
        flit_d    = flit_q;
        vld_d     = vld_q;
        if (config_spk_clear) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            flit_d  = '0;
            vld_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_nid_d = fifo_mem_q[rd_ptr_q];
                        idx_d     = '0;
                        state_d   = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cur_entry[0]) begin
                        flit_d  = {SPK_TYPE, cur_entry, {PADW{1'b0}}, payload};
                        vld_d   = 1'b1;
                        state_d = ST_SEND;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (vld_q && flit_out_rdy) begin
                        vld_d = 1'b0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_SCAN;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    vld_d   = 1'b0;
                end
            endcase
        end
    end

    // Fan-out FSM state and output registers.
    always_ff @(posedge clk_spk_out) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cur_nid_q <= '0;
            flit_q    <= '0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cur_nid_q <= cur_nid_d;
            flit_q    <= flit_d;
            vld_q     <= vld_d;
        end
    end

    assign flit_out     = flit_q;
    assign flit_out_vld = vld_q;
    assign spk_drop_cnt = drop_q;
    assign spk_out_busy = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_spk_out_pack.sv
// Testbench for spk_out_pack: randomized spikes and destination tables
// checked against a queue-based reference of the expected flit stream.

module tb_spk_out_pack;

  localparam int FW = 59;
  localparam int FTW = 3;
  localparam int NNW = 12;
  localparam int SW = 24;
  localparam int DST_WIDTH = 21;
  localparam int DST_DEPTH = 4;
  localparam int FIFO_AW = 4;
  localparam int DAW = 2;
  localparam int PADW = FW - FTW - DST_WIDTH - SW;

  // ---------------- clock / reset ----------------
  logic clk_spk_out = 1'b0;
  always #5 clk_spk_out = ~clk_spk_out;

  logic                 rst_n;
  logic                 soma_spk_out_vld;
  logic                 soma_spk_out_fire;
  logic [NNW-1:0]       soma_spk_out_nid;
  logic                 config_spk_enable;
  logic                 config_spk_clear;
  logic [SW-1:0]        config_spk_base;
  logic                 config_dst_we;
  logic [DAW-1:0]       config_dst_waddr;
  logic [DST_WIDTH-1:0] config_dst_wdata;
  logic [FW-1:0]        flit_out;
  logic                 flit_out_vld;
  logic                 flit_out_rdy;
  logic                 spk_out_busy;
  logic [15:0]          spk_drop_cnt;

  spk_out_pack dut (
    .clk_spk_out       (clk_spk_out),
    .rst_n             (rst_n),
    .soma_spk_out_vld  (soma_spk_out_vld),
    .soma_spk_out_fire (soma_spk_out_fire),
    .soma_spk_out_nid  (soma_spk_out_nid),
    .config_spk_enable (config_spk_enable),
    .config_spk_clear  (config_spk_clear),
    .config_spk_base   (config_spk_base),
    .config_dst_we     (config_dst_we),
    .config_dst_waddr  (config_dst_waddr),
    .config_dst_wdata  (config_dst_wdata),
    .flit_out          (flit_out),
    .flit_out_vld      (flit_out_vld),
    .flit_out_rdy      (flit_out_rdy),
    .spk_out_busy      (spk_out_busy),
    .spk_drop_cnt      (spk_drop_cnt)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic rand_rdy = 1'b0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] got_q[$];
  logic [DST_WIDTH-1:0] tbl_m [DST_DEPTH];
  logic [SW-1:0] base_m;
  int drop_m = 0;

  // Collect every transferred flit, sampled mid-cycle.
  always @(negedge clk_spk_out) begin
    if (rst_n && flit_out_vld && flit_out_rdy) got_q.push_back(flit_out);
  end

  // ---------------- reference model ----------------
  function automatic logic [FW-1:0] make_flit(input logic [DST_WIDTH-1:0] e,
                                              input logic [NNW-1:0] nid,
                                              input logic [SW-1:0] base);
    logic [SW-1:0] p;
    p = base + SW'(nid);
    return {3'b000, e, {PADW{1'b0}}, p};
  endfunction

  // One spike fans out to every valid table entry, lowest index first.
  task automatic expect_spike(input logic [NNW-1:0] nid);
    for (int i = 0; i < DST_DEPTH; i++) begin
      if (tbl_m[i][0]) exp_q.push_back(make_flit(tbl_m[i], nid, base_m));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_spk_out);
    #2;
    if (rand_rdy) flit_out_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic wr_tbl(input int addr, input logic [DST_WIDTH-1:0] data);
    config_dst_we = 1'b1;
    config_dst_waddr = DAW'(addr);
    config_dst_wdata = data;
    tick();
    config_dst_we = 1'b0;
    tbl_m[addr] = data;
  endtask

  task automatic set_base(input logic [SW-1:0] b);
    config_spk_base = b;
    base_m = b;
  endtask

  task automatic push_spike(input logic [NNW-1:0] nid);
    soma_spk_out_vld = 1'b1;
    soma_spk_out_fire = 1'b1;
    soma_spk_out_nid = nid;
    tick();
    soma_spk_out_vld = 1'b0;
    soma_spk_out_fire = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int i;
    i = 0;
    while (spk_out_busy && i < max_cyc) begin
      tick();
      i++;
    end
    n_vec++;
    if (spk_out_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_timeout: busy=%b after %0d cycles, required 0", name, spk_out_busy, i);
    end
  endtask

  task automatic wait_vld(input int max_cyc, input string name);
    int i;
    i = 0;
    while (!flit_out_vld && i < max_cyc) begin
      tick();
      i++;
    end
    n_vec++;
    if (flit_out_vld !== 1'b1) begin
      n_err++;
      $display("FAIL %s vld_timeout: vld=%b after %0d cycles, required 1", name, flit_out_vld, i);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < DST_DEPTH; i++) tbl_m[i] = '0;
    drop_m = 0;
    n_vec++;
    if (flit_out !== '0) begin n_err++; $display("FAIL reset_flit: got %h required 0", flit_out); end
    n_vec++;
    if (flit_out_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b required 0", flit_out_vld); end
    n_vec++;
    if (spk_out_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", spk_out_busy); end
    n_vec++;
    if (spk_drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d required 0", spk_drop_cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [FW-1:0] exp_f;
    wr_tbl(0, 21'h00A01);
    wr_tbl(1, 21'h0);
    wr_tbl(2, 21'h0);
    wr_tbl(3, 21'h0);
    set_base(24'h1000);
    flit_out_rdy = 1'b1;
    got_q.delete();
    exp_f = {3'b000, 21'h00A01, {PADW{1'b0}}, 24'h001005};
    push_spike(12'h005);
    n_vec++;
    if (flit_out_vld !== 1'b0 || spk_out_busy !== 1'b1) begin
      n_err++; $display("FAIL single_edge0: vld=%b busy=%b required vld=0 busy=1", flit_out_vld, spk_out_busy);
    end
    tick();
    n_vec++;
    if (flit_out_vld !== 1'b0) begin n_err++; $display("FAIL single_edge1: vld=%b required 0", flit_out_vld); end
    tick();
    n_vec++;
    if (flit_out_vld !== 1'b1 || flit_out !== exp_f) begin
      n_err++; $display("FAIL single_edge2: vld=%b flit=%h required vld=1 flit=%h", flit_out_vld, flit_out, exp_f);
    end
    wait_idle(50, "single");
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== exp_f) begin
      n_err++; $display("FAIL single_stream: got %0d flits, required 1 flit %h", got_q.size(), exp_f);
    end
  endtask

  task automatic test_two_dst();
    wr_tbl(0, 21'h0BEEF);
    wr_tbl(1, 21'h0BEEE);
    wr_tbl(2, 21'h1F003);
    wr_tbl(3, 21'h00010);
    set_base(24'hFFFFFE);
    flit_out_rdy = 1'b1;
    got_q.delete();
    exp_q.delete();
    expect_spike(12'd7);
    push_spike(12'd7);
    wait_idle(50, "two_dst");
    n_vec++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      n_err++; $display("FAIL two_dst_count: got %0d flits, required 2", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL two_dst_flit%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [FW-1:0] f;
    logic [NNW-1:0] nid;
    wr_tbl(0, DST_WIDTH'($urandom()) | 21'h1);
    wr_tbl(1, 21'h0);
    wr_tbl(2, 21'h0);
    wr_tbl(3, 21'h0);
    set_base(SW'($urandom()));
    flit_out_rdy = 1'b0;
    got_q.delete();
    nid = NNW'($urandom());
    push_spike(nid);
    wait_vld(20, "stall");
    f = flit_out;
    n_vec++;
    if (f !== make_flit(tbl_m[0], nid, base_m)) begin
      n_err++; $display("FAIL stall_flit: got %h required %h", f, make_flit(tbl_m[0], nid, base_m));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (flit_out_vld !== 1'b1 || flit_out !== f) begin
        n_err++; $display("FAIL stall_hold%0d: vld=%b flit=%h required vld=1 flit=%h", i, flit_out_vld, flit_out, f);
      end
    end
    flit_out_rdy = 1'b1;
    tick();
    flit_out_rdy = 1'b0;
    n_vec++;
    if (flit_out_vld !== 1'b0) begin n_err++; $display("FAIL stall_release: vld=%b required 0", flit_out_vld); end
    wait_idle(50, "stall");
    n_vec++;
    if (got_q.size() != 1) begin n_err++; $display("FAIL stall_transfers: got %0d required 1", got_q.size()); end
  endtask

  task automatic test_random_fanout();
    logic [NNW-1:0] nid;
    logic fire;
    int n;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DST_DEPTH; i++) wr_tbl(i, DST_WIDTH'($urandom()));
      set_base(SW'($urandom()));
      got_q.delete();
      exp_q.delete();
      rand_rdy = 1'b1;
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        nid = NNW'($urandom());
        fire = ($urandom_range(0, 3) != 0);
        soma_spk_out_vld = 1'b1;
        soma_spk_out_fire = fire;
        soma_spk_out_nid = nid;
        tick();
        soma_spk_out_vld = 1'b0;
        soma_spk_out_fire = 1'b0;
        if (fire) expect_spike(nid);
      end
      wait_idle(2000, "random");
      rand_rdy = 1'b0;
      flit_out_rdy = 1'b1;
      n_vec++;
      if (got_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL random%0d_count: got %0d flits required %0d", r, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL random%0d_flit%0d: got %h required %h", r, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [NNW-1:0] nids[$];
    wr_tbl(0, DST_WIDTH'($urandom()) | 21'h1);
    wr_tbl(1, 21'h0);
    wr_tbl(2, 21'h0);
    wr_tbl(3, 21'h0);
    set_base(SW'($urandom()));
    flit_out_rdy = 1'b0;
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < 20; k++) nids.push_back(NNW'($urandom()));
    soma_spk_out_vld = 1'b1;
    soma_spk_out_fire = 1'b1;
    for (int k = 0; k < 20; k++) begin
      soma_spk_out_nid = nids[k];
      tick();
    end
    soma_spk_out_vld = 1'b0;
    soma_spk_out_fire = 1'b0;
    repeat (3) tick();
    // Stalled output holds one spike in flight plus a full 16-deep queue.
    drop_m += 3;
    n_vec++;
    if (spk_drop_cnt !== 16'(drop_m)) begin
      n_err++; $display("FAIL overflow_drop: got %0d required %0d", spk_drop_cnt, drop_m);
    end
    for (int k = 0; k < 17; k++) expect_spike(nids[k]);
    flit_out_rdy = 1'b1;
    wait_idle(3000, "overflow");
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL overflow_count: got %0d flits required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL overflow_flit%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_no_push();
    logic [2:0] combo [3];
    combo[0] = 3'b101;  // vld, no fire, enabled
    combo[1] = 3'b110;  // vld, fire, disabled
    combo[2] = 3'b011;  // no vld, fire, enabled
    flit_out_rdy = 1'b1;
    got_q.delete();
    for (int c = 0; c < 3; c++) begin
      soma_spk_out_vld = combo[c][2];
      soma_spk_out_fire = combo[c][1];
      config_spk_enable = combo[c][0];
      for (int k = 0; k < 4; k++) begin
        soma_spk_out_nid = NNW'($urandom());
        tick();
        n_vec++;
        if (spk_out_busy !== 1'b0 || flit_out_vld !== 1'b0) begin
          n_err++; $display("FAIL no_push%0d: busy=%b vld=%b required 0 0", c, spk_out_busy, flit_out_vld);
        end
      end
    end
    soma_spk_out_vld = 1'b0;
    soma_spk_out_fire = 1'b0;
    config_spk_enable = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (got_q.size() != 0) begin n_err++; $display("FAIL no_push_flits: got %0d required 0", got_q.size()); end
  endtask

  task automatic test_clear();
    logic [NNW-1:0] nid;
    wr_tbl(0, DST_WIDTH'($urandom()) | 21'h1);
    wr_tbl(1, 21'h0);
    wr_tbl(2, 21'h0);
    wr_tbl(3, DST_WIDTH'($urandom()) | 21'h1);
    set_base(SW'($urandom()));
    flit_out_rdy = 1'b0;
    got_q.delete();
    exp_q.delete();
    soma_spk_out_vld = 1'b1;
    soma_spk_out_fire = 1'b1;
    for (int k = 0; k < 5; k++) begin
      soma_spk_out_nid = NNW'($urandom());
      tick();
    end
    soma_spk_out_vld = 1'b0;
    wait_vld(20, "clear");
    config_spk_clear = 1'b1;
    soma_spk_out_vld = 1'b1;
    soma_spk_out_nid = 12'h0AB;
    tick();
    config_spk_clear = 1'b0;
    soma_spk_out_vld = 1'b0;
    soma_spk_out_fire = 1'b0;
    n_vec++;
    if (flit_out_vld !== 1'b0 || spk_out_busy !== 1'b0) begin
      n_err++; $display("FAIL clear_state: vld=%b busy=%b required 0 0", flit_out_vld, spk_out_busy);
    end
    n_vec++;
    if (spk_drop_cnt !== 16'(drop_m)) begin
      n_err++; $display("FAIL clear_drop: got %0d required %0d", spk_drop_cnt, drop_m);
    end
    repeat (3) tick();
    n_vec++;
    if (spk_out_busy !== 1'b0 || got_q.size() != 0) begin
      n_err++; $display("FAIL clear_discard: busy=%b flits=%0d required 0 0", spk_out_busy, got_q.size());
    end
    flit_out_rdy = 1'b1;
    nid = NNW'($urandom());
    expect_spike(nid);
    push_spike(nid);
    wait_idle(50, "clear");
    n_vec++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      n_err++; $display("FAIL clear_after_count: got %0d flits required 2", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL clear_after_flit%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    flit_out_rdy = 1'b0;
    got_q.delete();
    push_spike(NNW'($urandom()));
    wait_vld(20, "rst_mid");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DST_DEPTH; i++) tbl_m[i] = '0;
    drop_m = 0;
    n_vec++;
    if (flit_out_vld !== 1'b0 || flit_out !== '0 || spk_out_busy !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_state: vld=%b flit=%h busy=%b required 0 0 0", flit_out_vld, flit_out, spk_out_busy);
    end
    n_vec++;
    if (spk_drop_cnt !== 16'(drop_m)) begin
      n_err++; $display("FAIL rst_mid_drop: got %0d required %0d", spk_drop_cnt, drop_m);
    end
    // With the table reset every entry is invalid: the spike is consumed silently.
    flit_out_rdy = 1'b1;
    push_spike(NNW'($urandom()));
    wait_idle(50, "rst_mid");
    n_vec++;
    if (got_q.size() != 0) begin n_err++; $display("FAIL rst_mid_table: got %0d flits required 0", got_q.size()); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst_n = 1'b0;
    soma_spk_out_vld = 1'b0;
    soma_spk_out_fire = 1'b0;
    soma_spk_out_nid = '0;
    config_spk_enable = 1'b1;
    config_spk_clear = 1'b0;
    config_spk_base = '0;
    base_m = '0;
    config_dst_we = 1'b0;
    config_dst_waddr = '0;
    config_dst_wdata = '0;
    flit_out_rdy = 1'b1;
    test_reset();
    test_single();
    test_two_dst();
    test_stall();
    test_random_fanout();
    test_overflow();
    test_no_push();
    test_clear();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
